// File: rtl/disp_mode_ctrl.sv
// View/edit sequencer for the six-digit clock display: browses views, runs the
// field-edit sequence, blinks the edited field and forces the time view on alarm.
module disp_mode_ctrl #(
  parameter int unsigned TIMEOUT_S  = 10,
  parameter int unsigned NUM_FIELDS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       alarm_ring,
  output logic [1:0] select,
  output logic       edit_en,
  output logic [1:0] edit_field,
  output logic       inc_pulse,
  output logic       sw_toggle,
  output logic [5:0] blink_mask
);

  localparam int unsigned CNT_W = 6;
  localparam int unsigned FLD_W = 2;

  localparam logic [1:0] ST_VIEW  = 2'd0;
  localparam logic [1:0] ST_EDIT  = 2'd1;
  localparam logic [1:0] ST_ALARM = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [FLD_W-1:0] FLD_LAST  = FLD_W'(NUM_FIELDS - 1);
  localparam logic [1:0]       SEL_STOPW = 2'd2;

  logic [1:0]       state, state_n;
  logic [1:0]       select_n;
  logic             edit_en_n;
  logic [FLD_W-1:0] field_n;
  logic             inc_n, sw_n;
  logic [5:0]       mask_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             phase, phase_n;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_VIEW;
      select     <= 2'd0;
      edit_en    <= 1'b0;
      edit_field <= '0;
      inc_pulse  <= 1'b0;
      sw_toggle  <= 1'b0;
      blink_mask <= '0;
      cnt        <= '0;
      phase      <= 1'b0;
    end else begin
      state      <= state_n;
      select     <= select_n;
      edit_en    <= edit_en_n;
      edit_field <= field_n;
      inc_pulse  <= inc_n;
      sw_toggle  <= sw_n;
      blink_mask <= mask_n;
      cnt        <= cnt_n;
      phase      <= phase_n;
    end
  end

  // Next state; priority alarm > set > mode > timeout
  always_comb begin
    state_n   = state;
    select_n  = select;
    edit_en_n = edit_en;
    field_n   = edit_field;
    inc_n     = 1'b0;
    sw_n      = 1'b0;
    cnt_n     = cnt;
    phase_n   = phase;

    if (alarm_ring) begin
      state_n   = ST_ALARM;
      select_n  = 2'd0;
      edit_en_n = 1'b0;
      field_n   = '0;
      cnt_n     = '0;
      phase_n   = 1'b0;
    end else begin
      case (state)
        ST_VIEW: begin
          if (btn_set) begin
            cnt_n = '0;
            if (select == SEL_STOPW) begin
              sw_n = 1'b1;
            end else begin
              state_n   = ST_EDIT;
              edit_en_n = 1'b1;
              field_n   = '0;
              phase_n   = 1'b0;
            end
          end else if (btn_mode) begin
            select_n = select + 2'd1;
            cnt_n    = '0;
          end else if (tick_1hz && select[0]) begin
            // Only the alarm and date views fall back to time
            if (cnt == CNT_LAST) begin
              select_n = 2'd0;
              cnt_n    = '0;
            end else if (cnt != CNT_MAX) begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end

        ST_EDIT: begin
          if (tick_2hz) phase_n = ~phase;
          if (btn_set) begin
            cnt_n = '0;
            if (edit_field == FLD_LAST) begin
              state_n   = ST_VIEW;
              edit_en_n = 1'b0;
              field_n   = '0;
              phase_n   = 1'b0;
            end else begin
              field_n = edit_field + FLD_W'(1);
            end
          end else if (btn_mode) begin
            inc_n = 1'b1;
            cnt_n = '0;
          end else if (tick_1hz) begin
            if (cnt == CNT_LAST) begin
              state_n   = ST_VIEW;
              select_n  = 2'd0;
              edit_en_n = 1'b0;
              field_n   = '0;
              cnt_n     = '0;
              phase_n   = 1'b0;
            end else if (cnt != CNT_MAX) begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end

        default: begin
          state_n   = ST_VIEW;
          select_n  = 2'd0;
          edit_en_n = 1'b0;
          field_n   = '0;
          cnt_n     = '0;
          phase_n   = 1'b0;
        end
      endcase
    end

    mask_n = '0;
    if (state_n == ST_EDIT) begin
      mask_n = 6'({2{phase_n}}) << {field_n, 1'b0};
    end
  end

endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Directed self-checking bench for disp_mode_ctrl: a vector table for the
// browse/edit/stopwatch flow plus sequences for timeout, alarm and async reset.
module tb_disp_mode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, tick_2hz, btn_mode, btn_set, alarm_ring;
  logic [1:0] select;
  logic       edit_en;
  logic [1:0] edit_field;
  logic       inc_pulse, sw_toggle;
  logic [5:0] blink_mask;

  int total = 0;
  int bad   = 0;

  disp_mode_ctrl #(.TIMEOUT_S(10), .NUM_FIELDS(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_mode(btn_mode), .btn_set(btn_set), .alarm_ring(alarm_ring),
    .select(select), .edit_en(edit_en), .edit_field(edit_field),
    .inc_pulse(inc_pulse), .sw_toggle(sw_toggle), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m, s, t1, t2, al;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[20];

  // {select, edit_en, edit_field, inc_pulse, sw_toggle, blink_mask}
  function automatic logic [12:0] ex(input logic [1:0] sel, input logic e,
                                     input logic [1:0] f, input logic i,
                                     input logic w, input logic [5:0] mk);
    return {sel, e, f, i, w, mk};
  endfunction

  function automatic vec_t mk_vec(input logic m, input logic s, input logic t1,
                                  input logic t2, input logic al, input logic [12:0] e);
    vec_t v;
    v.m = m; v.s = s; v.t1 = t1; v.t2 = t2; v.al = al; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [12:0] exp);
    logic [12:0] act;
    act = {select, edit_en, edit_field, inc_pulse, sw_toggle, blink_mask};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got sel=%0d en=%0d fld=%0d inc=%0d sw=%0d mask=%b, want sel=%0d en=%0d fld=%0d inc=%0d sw=%0d mask=%b",
               nm, act[12:11], act[10], act[9:8], act[7], act[6], act[5:0],
               exp[12:11], exp[10], exp[9:8], exp[7], exp[6], exp[5:0]);
    end
  endtask

  // One clock with the given inputs; outputs are then sampled 1 after the edge
  task automatic step(input logic m, input logic s, input logic t1,
                      input logic t2, input logic al);
    @(negedge clk);
    btn_mode = m; btn_set = s; tick_1hz = t1; tick_2hz = t2; alarm_ring = al;
    @(posedge clk);
    #1;
    btn_mode = 0; btn_set = 0; tick_1hz = 0; tick_2hz = 0;
  endtask

  initial begin
    rst = 1'b1;
    btn_mode = 0; btn_set = 0; tick_1hz = 0; tick_2hz = 0; alarm_ring = 0;

    tbl[0]  = mk_vec(1,0,0,0,0, ex(1,0,0,0,0,6'b000000));
    tbl[1]  = mk_vec(1,0,0,0,0, ex(2,0,0,0,0,6'b000000));
    tbl[2]  = mk_vec(1,0,0,0,0, ex(3,0,0,0,0,6'b000000));
    tbl[3]  = mk_vec(1,0,0,0,0, ex(0,0,0,0,0,6'b000000));
    tbl[4]  = mk_vec(0,1,0,0,0, ex(0,1,0,0,0,6'b000000));
    tbl[5]  = mk_vec(1,0,0,0,0, ex(0,1,0,1,0,6'b000000));
    tbl[6]  = mk_vec(0,0,0,0,0, ex(0,1,0,0,0,6'b000000));
    tbl[7]  = mk_vec(1,0,0,0,0, ex(0,1,0,1,0,6'b000000));
    tbl[8]  = mk_vec(0,1,0,0,0, ex(0,1,1,0,0,6'b000000));
    tbl[9]  = mk_vec(0,0,0,1,0, ex(0,1,1,0,0,6'b001100));
    tbl[10] = mk_vec(0,0,0,1,0, ex(0,1,1,0,0,6'b000000));
    tbl[11] = mk_vec(0,0,0,1,0, ex(0,1,1,0,0,6'b001100));
    tbl[12] = mk_vec(0,1,0,0,0, ex(0,1,2,0,0,6'b110000));
    tbl[13] = mk_vec(0,1,0,0,0, ex(0,0,0,0,0,6'b000000));
    tbl[14] = mk_vec(1,0,0,0,0, ex(1,0,0,0,0,6'b000000));
    tbl[15] = mk_vec(1,0,0,0,0, ex(2,0,0,0,0,6'b000000));
    tbl[16] = mk_vec(0,1,0,0,0, ex(2,0,0,0,1,6'b000000));
    tbl[17] = mk_vec(0,0,0,0,0, ex(2,0,0,0,0,6'b000000));
    tbl[18] = mk_vec(1,1,0,0,0, ex(2,0,0,0,1,6'b000000));
    tbl[19] = mk_vec(0,0,0,0,0, ex(2,0,0,0,0,6'b000000));

    repeat (3) @(posedge clk);
    #1 chk("reset_state", ex(0,0,0,0,0,6'b000000));
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].m, tbl[i].s, tbl[i].t1, tbl[i].t2, tbl[i].al);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Stopwatch view never times out
    for (int i = 0; i < 20; i++) step(0,0,1,0,0);
    chk("sel2_no_timeout", ex(2,0,0,0,0,6'b000000));

    // Date view: falls back exactly on the tenth tick
    step(1,0,0,0,0);
    for (int i = 0; i < 9; i++) begin
      step(0,0,1,0,0);
      step(0,0,0,0,0);
    end
    chk("sel3_tick9_holds", ex(3,0,0,0,0,6'b000000));
    step(0,0,1,0,0);
    chk("sel3_tick10_falls", ex(0,0,0,0,0,6'b000000));

    // Button coincident with terminal tick wins and restarts the count
    step(1,0,0,0,0);
    for (int i = 0; i < 9; i++) step(0,0,1,0,0);
    step(1,0,1,0,0);
    chk("btn_beats_timeout", ex(2,0,0,0,0,6'b000000));

    // Edit mode times out to view 0
    step(1,0,0,0,0);
    step(0,1,0,0,0);
    chk("edit_enter_sel3", ex(3,1,0,0,0,6'b000000));
    for (int i = 0; i < 9; i++) step(0,0,1,0,0);
    chk("edit_tick9_holds", ex(3,1,0,0,0,6'b000000));
    step(0,0,1,0,0);
    chk("edit_timeout", ex(0,0,0,0,0,6'b000000));

    // Alarm abandons an edit on field 2; buttons are ignored
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    step(0,1,0,0,0);
    chk("pre_alarm_field2", ex(0,1,2,0,0,6'b000000));
    for (int i = 0; i < 50; i++) begin
      step(1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
           1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 1'b1);
      chk($sformatf("alarm_cyc%0d", i), ex(0,0,0,0,0,6'b000000));
    end
    step(0,0,0,0,0);
    chk("alarm_release", ex(0,0,0,0,0,6'b000000));
    step(1,0,0,0,0);
    chk("after_alarm_view", ex(1,0,0,0,0,6'b000000));

    // Asynchronous reset in the middle of an edit
    step(0,1,0,0,0);
    step(0,0,0,1,0);
    chk("pre_rst_mask", ex(1,1,0,0,0,6'b000011));
    step(1,0,0,0,0);
    chk("pre_rst_inc", ex(1,1,0,1,0,6'b000011));
    #2 rst = 1'b1;
    #1 chk("async_rst", ex(0,0,0,0,0,6'b000000));
    @(negedge clk) rst = 1'b0;
    step(0,0,0,0,0);
    chk("post_rst_idle", ex(0,0,0,0,0,6'b000000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/disp_mode_ctrl.md
Name: disp_mode_ctrl

Overview:
Sequencer for the six-digit display multiplexer of the clock. It owns the 2-bit view select:
- 0 = time
- 1 = alarm
- 2 = stopwatch
- 3 = date

It steps through views on user buttons and returns to the time view after inactivity. It runs the field-edit sequence, blinks the field being edited, and forces the time view while the alarm rings.

Parameters:
TIMEOUT_S, 10, seconds of no button activity before views 1/3 or edit mode fall back to view 0 (range 2..63)
NUM_FIELDS, 3, editable two-digit fields per view (hours, minutes, seconds / day, month, year)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous active-high reset
tick_1hz  input  1  one-cycle strobe, once per second
tick_2hz  input  1  one-cycle strobe, twice per second (blink phase)
btn_mode  input  1  debounced one-cycle press pulse, MODE button
btn_set  input  1  debounced one-cycle press pulse, SET button
alarm_ring  input  1  level, high while alarm sounds
select  output  2  view select to display mux
edit_en  output  1  high while editing a field
edit_field  output  2  field under edit, 0..NUM_FIELDS-1
inc_pulse  output  1  one-cycle request to increment the edited field
sw_toggle  output  1  one-cycle stopwatch start/stop request
blink_mask  output  6  digit blank mask; bit k blanks digit k

Behaviour:
- Clock, reset and registering
  - Single clock domain.
  - All outputs are registered and change on the clk edge after the causing input is sampled (1-cycle latency).
- Reset
  - State VIEW, select=0, edit_en=0, edit_field=0.
  - inc_pulse=0, sw_toggle=0, blink_mask=0.
  - Timeout counter 0, blink phase 0.
  - Reset is asynchronous and may occur mid-edit; edit is abandoned with no pulse emitted.
- States: VIEW (browsing, select=0..3), EDIT (select held, editing one field), ALARM (forced view).
- Priority per cycle: alarm_ring > btn_set > btn_mode > timeout. If btn_set and btn_mode arrive together, btn_set is acted on and btn_mode is dropped.
- VIEW:
  - btn_mode: select <= select+1, wrapping 3->0.
  - btn_set with select in {0,1,3}: enter EDIT, edit_field=0.
  - btn_set with select=2: sw_toggle=1 for one cycle; stay in VIEW.
- EDIT:
  - btn_mode: inc_pulse=1 for one cycle; field unchanged.
  - btn_set: edit_field+1. From NUM_FIELDS-1 instead return to VIEW, same select, edit_field=0.
  - blink_mask: bits 2*edit_field and 2*edit_field+1 equal blink phase; all other bits 0.
  - Blink phase toggles on each tick_2hz; phase clears to 0 on entering EDIT, so the field is visible first.
  - blink_mask=0 in every state other than EDIT.
- Timeout counter
  - Cleared on any btn_mode/btn_set pulse and on every state/select change.
  - Increments on tick_1hz only in VIEW with select in {1,3}, or in EDIT; saturates.
  - When it reaches TIMEOUT_S: go to VIEW, select=0, edit_en=0, no inc_pulse.
  - select=0 and select=2 views never time out in VIEW.
  - A button pulse coincident with the terminal tick wins; counter clears, no fallback.
- ALARM
  - Entered from any state when alarm_ring=1; an edit in progress is abandoned.
  - select=0; buttons ignored, no pulses emitted.
  - On alarm_ring falling: VIEW, select=0, counter 0.
- inc_pulse and sw_toggle are never high in the same cycle and never stay high longer than one cycle.

Test Plan:
- Reset then 4 btn_mode pulses -> select 1,2,3,0, each one cycle after its pulse; all other outputs 0.
- select=1, no buttons, 10 tick_1hz -> select=0 the cycle after the 10th tick. Repeat with select=2 and 20 ticks -> select stays 2.
- select=0: btn_set, 2x btn_mode, btn_set, btn_set, btn_set:
  - edit_en rises.
  - Two one-cycle inc_pulse.
  - edit_field 0->1->2.
  - Third btn_set exits to VIEW with select=0.
  - With edit_field=1, blink_mask toggles 000000/001100 on tick_2hz.
- select=2, btn_set -> single-cycle sw_toggle, select stays 2. btn_set and btn_mode in the same cycle at select=2 -> sw_toggle only, select unchanged.
- EDIT with edit_field=2, assert alarm_ring for 50 cycles with button pulses -> select=0, edit_en=0, blink_mask=0, no pulses. After release, VIEW select=0.
- Assert rst asynchronously mid-EDIT between clock edges -> all outputs 0 immediately, before the next clk edge.
